// File: rtl/cpu_defs.sv
// Shared types for the execute-stage branch-resolution unit (bru_resolve, bru_cond).
package cpu_defs;

  localparam int unsigned RegXlen = 32;

  typedef enum logic [3:0] {
    OpBeq  = 4'd0,
    OpBne  = 4'd1,
    OpBlt  = 4'd2,
    OpBltu = 4'd3,
    OpBge  = 4'd4,
    OpBgeu = 4'd5,
    OpB    = 4'd6,
    OpBl   = 4'd7,
    OpJirl = 4'd8
  } bru_op_t;

  typedef enum logic {
    BruIdle,
    BruWait
  } bru_fsm_t;

  typedef struct packed {
    logic               valid;
    logic               taken;
    logic [RegXlen-1:0] link;
    logic [RegXlen-1:0] nxt_pc;
    logic               mis;
  } bru_result_t;

  function automatic logic op_links(bru_op_t op);
    return (op == OpBl) || (op == OpJirl);
  endfunction

endpackage

// File: rtl/bru_cond.sv
// Combinational branch-condition evaluator (eq / signed lt / unsigned lt).
module bru_cond
  import cpu_defs::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  bru_op_t         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            taken_o
);

  logic eq, lt, ltu;

  assign eq  = (a_i == b_i);
  assign lt  = ($signed(a_i) < $signed(b_i));
  assign ltu = (a_i < b_i);

  // Unconditional jumps and undefined encodings both resolve as taken.
  always_comb begin
    taken_o = 1'b1;
    case (op_i)
      OpBeq:   taken_o = eq;
      OpBne:   taken_o = ~eq;
      OpBlt:   taken_o = lt;
      OpBge:   taken_o = ~lt;
      OpBltu:  taken_o = ltu;
      OpBgeu:  taken_o = ~ltu;
      default: taken_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/bru_resolve.sv
// Registered branch-resolution unit: resolves direction/target, raises a held redirect and a
// one-cycle predictor update. Optional perf counters under `BRU_PERF_CNT_EN`.
module bru_resolve
  import cpu_defs::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef BRU_PERF_CNT_EN
  input  logic            perf_clr,
  output logic [31:0]     perf_br_cnt,
  output logic [31:0]     perf_mis_cnt,
`endif
  input  logic            in_valid,
  input  bru_op_t         in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_offs,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output logic            out_taken,
  output logic [XLEN-1:0] out_link,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            upd_valid,
  output logic [XLEN-1:0] upd_pc,
  output logic [XLEN-1:0] upd_target,
  output logic            upd_taken,
  output logic            upd_mispred
);

  localparam logic [XLEN-1:0] InstInc = XLEN'(INST_BYTES);

  bru_fsm_t        state;
  logic            taken;
  logic            accept;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall;
  bru_result_t     res;

  bru_cond #(
    .XLEN (XLEN)
  ) u_cond (
    .op_i    (in_op),
    .a_i     (in_a),
    .b_i     (in_b),
    .taken_o (taken)
  );

  assign target = (in_op == OpJirl) ? (in_a + in_offs) : (in_pc + in_offs);
  assign fall   = in_pc + InstInc;
  // Anything arriving while a redirect is outstanding is on the wrong path.
  assign accept = in_valid & ~stall & ~flush & (state == BruIdle);

  // Result fields are RegXlen wide; XLEN is expected to match.
  always_comb begin
    res        = '0;
    res.valid  = accept;
    res.taken  = taken;
    res.link   = op_links(in_op) ? fall : '0;
    res.nxt_pc = taken ? target : fall;
    res.mis    = (taken != in_pred_taken) | (taken & (target != in_pred_target));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BruIdle;
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_link       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_target     <= '0;
      upd_taken      <= 1'b0;
      upd_mispred    <= 1'b0;
    end else if (flush) begin
      state          <= BruIdle;
      out_valid      <= 1'b0;
      upd_valid      <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      upd_valid <= res.valid;
      if (!stall) begin
        out_valid <= res.valid;
      end
      if (res.valid) begin
        out_taken   <= res.taken;
        out_link    <= res.link;
        upd_pc      <= in_pc;
        upd_target  <= target;
        upd_taken   <= res.taken;
        upd_mispred <= res.mis;
      end
      case (state)
        BruIdle: begin
          if (res.valid && res.mis) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= res.nxt_pc;
            state          <= BruWait;
          end
        end
        BruWait: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            state          <= BruIdle;
          end
        end
        default: state <= BruIdle;
      endcase
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_cnt  <= '0;
      perf_mis_cnt <= '0;
    end else if (perf_clr) begin
      perf_br_cnt  <= '0;
      perf_mis_cnt <= '0;
    end else begin
      if (res.valid && (perf_br_cnt != '1)) begin
        perf_br_cnt <= perf_br_cnt + 32'd1;
      end
      if (res.valid && res.mis && (perf_mis_cnt != '1)) begin
        perf_mis_cnt <= perf_mis_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bru_resolve.sv
// Scoreboard bench for bru_resolve: random + directed branches against a behavioural model.
module tb_bru_resolve;
  import cpu_defs::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  bru_op_t     in_op;
  logic [31:0] in_a, in_b, in_pc, in_offs, in_pred_target;
  logic        in_pred_taken, stall, flush, redirect_ready;
  logic        out_valid, out_taken, redirect_valid, upd_valid, upd_taken, upd_mispred;
  logic [31:0] out_link, redirect_pc, upd_pc, upd_target;
`ifdef BRU_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] perf_br_cnt, perf_mis_cnt;
  int unsigned m_br, m_mis;
`endif

  bru_resolve #(
    .XLEN       (32),
    .INST_BYTES (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef BRU_PERF_CNT_EN
    .perf_clr       (perf_clr),
    .perf_br_cnt    (perf_br_cnt),
    .perf_mis_cnt   (perf_mis_cnt),
`endif
    .in_valid       (in_valid),
    .in_op          (in_op),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_pc          (in_pc),
    .in_offs        (in_offs),
    .in_pred_taken  (in_pred_taken),
    .in_pred_target (in_pred_target),
    .stall          (stall),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_taken      (out_taken),
    .out_link       (out_link),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .upd_mispred    (upd_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] link;
    logic [31:0] nxt;
    logic        taken;
    logic        mis;
  } exp_t;

  exp_t        out_q[$];
  logic [31:0] redir_q[$];
  logic        pend;
  logic        stall_s, flush_s;
  int unsigned n_cmp, n_err;

  always @(posedge clk) begin
    stall_s <= stall;
    flush_s <= flush;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(bru_op_t op, logic [31:0] a, logic [31:0] b,
                                     logic [31:0] pc, logic [31:0] offs, logic pt,
                                     logic [31:0] ptgt);
    exp_t e;
    int   sa, sb;
    sa = a;
    sb = b;
    case (op)
      OpBeq:   e.taken = (a == b);
      OpBne:   e.taken = (a != b);
      OpBlt:   e.taken = (sa < sb);
      OpBge:   e.taken = (sa >= sb);
      OpBltu:  e.taken = (a < b);
      OpBgeu:  e.taken = (a >= b);
      default: e.taken = 1'b1;
    endcase
    e.pc     = pc;
    e.target = (op == OpJirl) ? a + offs : pc + offs;
    e.link   = (op == OpBl || op == OpJirl) ? pc + 32'd4 : 32'd0;
    e.nxt    = e.taken ? e.target : pc + 32'd4;
    e.mis    = (e.taken != pt) || (e.taken && (e.target != ptgt));
    return e;
  endfunction

  // Applies the rules to whatever the DUT samples at this edge.
  task automatic model_step();
    exp_t e;
    if (!rst_n) begin
      pend = 1'b0;
      out_q.delete();
      redir_q.delete();
`ifdef BRU_PERF_CNT_EN
      m_br  = 0;
      m_mis = 0;
`endif
      return;
    end
`ifdef BRU_PERF_CNT_EN
    if (perf_clr) begin
      m_br  = 0;
      m_mis = 0;
    end
`endif
    if (flush) begin
      pend = 1'b0;
    end else if (!pend) begin
      if (in_valid && !stall) begin
        e = ref_model(in_op, in_a, in_b, in_pc, in_offs, in_pred_taken, in_pred_target);
        out_q.push_back(e);
`ifdef BRU_PERF_CNT_EN
        if (!perf_clr) begin
          m_br++;
          if (e.mis) m_mis++;
        end
`endif
        if (e.mis) begin
          pend = 1'b1;
          redir_q.push_back(e.nxt);
        end
      end
    end else if (redirect_ready) begin
      pend = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bru_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] offs, input logic pt,
                       input logic [31:0] ptgt);
    in_valid       = 1'b1;
    in_op          = op;
    in_a           = a;
    in_b           = b;
    in_pc          = pc;
    in_offs        = offs;
    in_pred_taken  = pt;
    in_pred_target = ptgt;
  endtask

  // Monitor: pops expectations whenever the DUT reports a resolved branch.
  initial begin
    exp_t        e;
    logic        prv_rv, prv_ov, prv_tk;
    logic [31:0] prv_rpc, prv_link;
    prv_rv = 0; prv_ov = 0; prv_tk = 0; prv_rpc = 0; prv_link = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prv_rv = 0; prv_ov = 0; prv_tk = 0; prv_rpc = 0; prv_link = 0;
      end else begin
        if (upd_valid) begin
          if (out_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_upd: got upd_valid=1 expected no branch at %0t", $time);
          end else begin
            e = out_q.pop_front();
            chk("out_valid", out_valid, 1);
            chk("out_taken", out_taken, e.taken);
            chk("out_link", out_link, e.link);
            chk("upd_pc", upd_pc, e.pc);
            chk("upd_target", upd_target, e.target);
            chk("upd_taken", upd_taken, e.taken);
            chk("upd_mispred", upd_mispred, e.mis);
          end
        end else if (stall_s && !flush_s) begin
          chk("hold_valid", out_valid, prv_ov);
          chk("hold_taken", out_taken, prv_tk);
          chk("hold_link", out_link, prv_link);
        end else begin
          chk("out_valid_idle", out_valid, 0);
        end
        chk("redirect_valid", redirect_valid, pend);
        if (redirect_valid && !prv_rv) begin
          if (redir_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_redirect: got pc %h expected none", redirect_pc);
          end else begin
            chk("redirect_pc", redirect_pc, redir_q.pop_front());
          end
        end else if (redirect_valid) begin
          chk("redirect_stable", redirect_pc, prv_rpc);
        end
        prv_rv = redirect_valid; prv_rpc = redirect_pc;
        prv_ov = out_valid; prv_tk = out_taken; prv_link = out_link;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_redirect_valid"}, redirect_valid, 0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
    chk({tag, "_upd_valid"}, upd_valid, 0);
    chk({tag, "_out_link"}, out_link, 0);
    chk({tag, "_upd_pc"}, upd_pc, 0);
`ifdef BRU_PERF_CNT_EN
    chk({tag, "_perf_br"}, perf_br_cnt, 0);
    chk({tag, "_perf_mis"}, perf_mis_cnt, 0);
`endif
  endtask

  initial begin
    n_cmp = 0; n_err = 0; pend = 0;
    in_valid = 0; in_op = OpBeq; in_a = 0; in_b = 0; in_pc = 0; in_offs = 0;
    in_pred_taken = 0; in_pred_target = 0; stall = 0; flush = 0; redirect_ready = 0;
`ifdef BRU_PERF_CNT_EN
    perf_clr = 0; m_br = 0; m_mis = 0;
`endif
    rst_n = 1;
    #2 rst_n = 0;
    #1 chk_all_zero("reset");
    tick(); tick();
    rst_n = 1;

    // BEQ correctly predicted taken
    drive(OpBeq, 32'd5, 32'd5, 32'h1000, 32'h20, 1'b1, 32'h1020);
    tick(); in_valid = 0;
    chk("beq_taken", out_taken, 1);
    chk("beq_upd_valid", upd_valid, 1);
    chk("beq_mispred", upd_mispred, 0);
    chk("beq_no_redirect", redirect_valid, 0);

    // BLT signed: -1 < 1 taken, predicted not taken
    drive(OpBlt, 32'hFFFF_FFFF, 32'd1, 32'h2000, 32'h40, 1'b0, 32'h0);
    tick(); in_valid = 0;
    chk("blt_redirect", redirect_valid, 1);
    chk("blt_redirect_pc", redirect_pc, 32'h2040);
    redirect_ready = 1;
    tick(); redirect_ready = 0;
    chk("blt_redirect_done", redirect_valid, 0);
    drive(OpBltu, 32'hFFFF_FFFF, 32'd1, 32'h2000, 32'h40, 1'b0, 32'h0);
    tick(); in_valid = 0;
    chk("bltu_taken", out_taken, 0);
    chk("bltu_no_redirect", redirect_valid, 0);

    // JIRL mispredicted target, then two wrong-path branches while fetch stalls
    drive(OpJirl, 32'h8000, 32'd0, 32'h3000, 32'h10, 1'b1, 32'h9000);
    tick();
    chk("jirl_redirect_pc", redirect_pc, 32'h8010);
    chk("jirl_link", out_link, 32'h3004);
    drive(OpBeq, 32'd1, 32'd1, 32'h3004, 32'h8, 1'b0, 32'h0);
    tick(); in_valid = 0;
    chk("squash1_valid", out_valid, 0);
    chk("squash1_upd", upd_valid, 0);
    tick();
    drive(OpBne, 32'd1, 32'd2, 32'h3008, 32'h8, 1'b0, 32'h0);
    tick();
    chk("squash2_upd", upd_valid, 0);
    chk("wait_redirect_pc", redirect_pc, 32'h8010);
    redirect_ready = 1;   // ready and a wrong-path branch in the same cycle
    tick(); in_valid = 0; redirect_ready = 0;
    chk("ready_drop", redirect_valid, 0);
    chk("ready_squash_upd", upd_valid, 0);

    // Flush during WAIT
    drive(OpB, 32'd0, 32'd0, 32'h4000, 32'h100, 1'b0, 32'h0);
    tick(); in_valid = 0;
    chk("b_redirect", redirect_valid, 1);
    flush = 1;
    tick(); flush = 0;
    chk("flush_drop", redirect_valid, 0);
    drive(OpBeq, 32'd1, 32'd2, 32'h4100, 32'h20, 1'b0, 32'h0);
    tick(); in_valid = 0;
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_upd", upd_valid, 1);

    // Stall holds outputs and ignores inputs
    drive(OpBl, 32'd0, 32'd0, 32'h5000, 32'h8, 1'b1, 32'h5008);
    tick();
    stall = 1; in_op = OpBne;
    tick(); tick();
    chk("stall_hold_valid", out_valid, 1);
    chk("stall_hold_link", out_link, 32'h5004);
    chk("stall_no_upd", upd_valid, 0);
    stall = 0; in_valid = 0;
    tick();

    // Async reset mid-WAIT
    drive(OpBne, 32'd1, 32'd2, 32'h6000, 32'h40, 1'b0, 32'h0);
    tick(); in_valid = 0;
    chk("pre_reset_redirect", redirect_valid, 1);
    #2 rst_n = 0;
    #1 chk_all_zero("async_reset");
    tick();
    rst_n = 1;

    // Four branches, last one mispredicted
    redirect_ready = 1;
    for (int i = 0; i < 3; i++) begin
      drive(OpBeq, 32'd3, 32'd3, 32'h7000 + 32'(i * 4), 32'h10, 1'b1, 32'h7010 + 32'(i * 4));
      tick();
    end
    drive(OpB, 32'd0, 32'd0, 32'h7100, 32'h200, 1'b0, 32'h0);
    tick(); in_valid = 0;
    tick();
`ifdef BRU_PERF_CNT_EN
    chk("perf_br_4", perf_br_cnt, 4);
    chk("perf_mis_1", perf_mis_cnt, 1);
`endif

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      bru_op_t     op;
      logic [31:0] a, b, pc, offs, tg;
      logic        pt;
      op   = bru_op_t'(4'($urandom_range(0, 15)));
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc   = 32'($urandom_range(0, 32'hFFFF)) << 2;
      offs = 32'($urandom_range(0, 4095)) << 2;
      if ($urandom_range(0, 1) == 1) offs = -offs;
      pt   = 1'($urandom_range(0, 1));
      tg   = (op == OpJirl) ? a + offs : pc + offs;
      drive(op, a, b, pc, offs, pt, ($urandom_range(0, 3) != 0) ? tg : $urandom);
      in_valid       = ($urandom_range(0, 9) < 7);
      stall          = ($urandom_range(0, 9) == 0);
      flush          = ($urandom_range(0, 29) == 0);
      redirect_ready = 1'($urandom_range(0, 1));
`ifdef BRU_PERF_CNT_EN
      perf_clr = ($urandom_range(0, 99) == 0);
`endif
      tick();
    end
    in_valid = 0; stall = 0; flush = 0; redirect_ready = 1;
`ifdef BRU_PERF_CNT_EN
    perf_clr = 0;
`endif
    repeat (4) tick();
    chk("out_q_drained", out_q.size(), 0);
    chk("redir_q_drained", redir_q.size(), 0);
`ifdef BRU_PERF_CNT_EN
    chk("perf_br_final", perf_br_cnt, m_br);
    chk("perf_mis_final", perf_mis_cnt, m_mis);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bru_resolve.md
Name: bru_resolve

Overview:
- Registered branch-resolution unit in the execute stage; next generation of the combinational branch-condition unit.
- Evaluates the branch condition, computes target and link address, and compares the outcome against the frontend prediction.
- Raises a held redirect toward fetch and a one-cycle predictor-update pulse.
- While a redirect is pending, all younger wrong-path branches are squashed.

Parameters:
- XLEN, 32, data and address width.
- INST_BYTES, 4, fall-through increment; also used for the link address.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  branch/jump op present this cycle
- in_op  in  bru_op_t  BEQ/BNE/BLT/BLTU/BGE/BGEU/B/BL/JIRL
- in_a, in_b  in  XLEN  rj, rd operands
- in_pc  in  XLEN  PC of the branch
- in_offs  in  XLEN  sign-extended byte offset
- in_pred_taken  in  1  frontend prediction
- in_pred_target  in  XLEN  frontend predicted target
- stall  in  1  hold output register
- flush  in  1  kill (from older exception/ertn)
- out_valid  out  1  resolved branch valid
- out_taken  out  1  actual direction
- out_link  out  XLEN  in_pc+INST_BYTES for BL/JIRL, else 0
- redirect_valid  out  1  mispredict redirect request
- redirect_pc  out  XLEN  correct next PC
- redirect_ready  in  1  fetch accepts redirect
- upd_valid  out  1  predictor update pulse
- upd_pc, upd_target  out  XLEN  update info
- upd_taken, upd_mispred  out  1  update info

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM=IDLE.
- Condition: eq, signed lt, unsigned lt as usual. B/BL/JIRL are always taken. An undefined op is treated as taken.
- Target: JIRL uses in_a+in_offs; all others use in_pc+in_offs. Both are XLEN modulo adds, wrap-around ignored. Fall-through is in_pc+INST_BYTES.
- Correct next PC: nxt = taken ? target : fall-through.
- Mispredict: mis = (taken != in_pred_taken) | (taken & (target != in_pred_target)).
- Latency: 1 cycle. Inputs sampled at posedge produce out_* and upd_* in the following cycle.
- stall=1: out_* hold, upd_valid=0, inputs ignored. Redirect handshake still progresses.
- flush=1: next out_valid=0, upd_valid=0. Any pending redirect is dropped and the FSM goes to IDLE. flush has priority over all other events.
- FSM state IDLE:
  - Accepted valid branch with mis=1 → redirect_valid=1, redirect_pc=nxt next cycle, go to WAIT.
  - Accepted valid branch with mis=0 → out/upd only, no redirect.
- FSM state WAIT:
  - redirect_valid and redirect_pc are held stable until redirect_ready=1 is sampled. Then redirect_valid=0 next cycle and go to IDLE.
  - in_valid is wrong-path: squashed, producing no out_valid, upd_valid or redirect.
  - If redirect_ready and in_valid arrive in the same cycle, that input is still squashed.
- upd_valid pulses 1 cycle per accepted non-squashed branch, for both correct and mispredicted outcomes.
- Reset mid-WAIT: redirect is lost and the FSM returns to IDLE; fetch restarts from the reset vector.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined: adds two 32-bit saturating counters, perf_br_cnt (accepted branches) and perf_mis_cnt (mispredicts). They are exposed as output ports of the same names, reset to 0, and clear on a perf_clr input.
- Undefined: these ports and the logic are absent; behaviour is otherwise identical.

Decomposition:
- bru_op_t, the BRU_FSM state enum, and a bru_result_t struct {valid, taken, link, nxt_pc, mis} belong in cpu_defs package.
- Sub-module bru_cond: the combinational eq/lt/ltu condition evaluator, instantiated once.

Test Plan:
- BEQ a=5 b=5, pc=0x1000, offs=0x20, pred_taken=1, pred_target=0x1020 → next cycle out_taken=1, upd_valid=1, upd_mispred=0, no redirect.
- BLT a=0xFFFFFFFF b=1, pred_taken=0, pc=0x2000, offs=0x40 → redirect_valid=1, redirect_pc=0x2040. Same operands with BLTU → taken=0, no redirect.
- JIRL a=0x8000, offs=0x10, pc=0x3000, pred_target=0x9000 → redirect_pc=0x8010, out_link=0x3004.
- Mispredict with redirect_ready=0 for 3 cycles while 2 more branches arrive → redirect_pc stable, both branches squashed (no out_valid/upd_valid). Ready=1 → redirect_valid=0 next cycle.
- flush=1 asserted during WAIT → redirect_valid=0 next cycle, FSM=IDLE, next branch resolves normally.
- rst_n pulled low mid-WAIT (asynchronously) → all outputs 0 immediately. With BRU_PERF_CNT_EN, 4 branches with 1 mispredict → perf_br_cnt=4, perf_mis_cnt=1.
